// File: rtl/demux8_seq.sv
// rtl/demux8_seq.sv - 8-slot TDM receive deserializer with atomic publish of all channels.
// Optional parity beat enabled by defining DEMUX8_PARITY_EN.
module demux8_seq #(
  parameter int WIDTH = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [WIDTH-1:0]   din,
  input  logic               din_valid,
  input  logic               sof,
  output logic [8*WIDTH-1:0] y,
  output logic               frame_done,
  output logic               parity_err,
  output logic               busy,
  output logic [3:0]         slot
);

  typedef enum logic {IDLE, FILL} state_t;

`ifdef DEMUX8_PARITY_EN
  localparam logic [3:0] LAST_SLOT = 4'd8;
`else
  localparam logic [3:0] LAST_SLOT = 4'd7;
`endif

  state_t               state_q, state_d;
  logic [3:0]           slot_q, slot_d;
  logic [8*WIDTH-1:0]   stage_q, stage_d;
  logic [8*WIDTH-1:0]   y_q, y_d;
  logic                 done_q, done_d;
  logic                 perr_q, perr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      slot_q  <= 4'd0;
      stage_q <= '0;
      y_q     <= '0;
      done_q  <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      stage_q <= stage_d;
      y_q     <= y_d;
      done_q  <= done_d;
      perr_q  <= perr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    stage_d = stage_q;
    y_d     = y_q;
    done_d  = 1'b0;
    perr_d  = 1'b0;
    if (din_valid) begin
      // sof wins over completion, so an abort on the final beat never publishes
      if (sof) begin
        stage_d[WIDTH-1:0] = din;
        slot_d             = 4'd1;
        state_d            = FILL;
      end else if (state_q == FILL) begin
        if (slot_q == LAST_SLOT) begin
          state_d = IDLE;
          slot_d  = 4'd0;
`ifdef DEMUX8_PARITY_EN
          if ((^stage_q ^ din[0]) == 1'b0) begin
            y_d    = stage_q;
            done_d = 1'b1;
          end else begin
            perr_d = 1'b1;
          end
`else
          y_d    = {din, stage_q[7*WIDTH-1:0]};
          done_d = 1'b1;
`endif
        end else begin
          for (int k = 0; k < 8; k++) begin
            if (slot_q == 4'(k)) stage_d[k*WIDTH +: WIDTH] = din;
          end
          slot_d = slot_q + 4'd1;
        end
      end
    end
  end

  assign y          = y_q;
  assign frame_done = done_q;
  assign parity_err = perr_q;
  assign busy       = (state_q == FILL);
  assign slot       = slot_q;

endmodule

// File: tb/tb_demux8_seq.sv
// tb/tb_demux8_seq.sv - scoreboard bench for demux8_seq (WIDTH=1).
// Frame length follows DEMUX8_PARITY_EN.
module tb_demux8_seq;

  localparam int W = 1;
`ifdef DEMUX8_PARITY_EN
  localparam int FLEN = 9;
`else
  localparam int FLEN = 8;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [W-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         sof = 1'b0;
  logic [8*W-1:0] y;
  logic         frame_done;
  logic         parity_err;
  logic         busy;
  logic [3:0]   slot;

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  logic [8:0] exp_q[$];
  logic [7:0] model_y = 8'h00;

  demux8_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .sof(sof),
    .y(y), .frame_done(frame_done), .parity_err(parity_err), .busy(busy), .slot(slot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: each pulse pops one entry; bit 8 set means a parity rejection is expected
  always @(negedge clk) begin
    logic [8:0] e;
    if (!rst && (frame_done || parity_err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_pulse done=%b perr=%b y=%h want no pulse", frame_done, parity_err, y);
      end else begin
        e = exp_q.pop_front();
        if ({parity_err, frame_done, y} !== {e[8], ~e[8], e[7:0]})
          $display("FAIL scoreboard got perr=%b done=%b y=%h want perr=%b done=%b y=%h",
                   parity_err, frame_done, y, e[8], ~e[8], e[7:0]);
        else n_pass++;
      end
    end
  end

  task automatic beat(input logic d, input logic s, input logic v);
    din = d; sof = s; din_valid = v;
    @(posedge clk); #1;
    din_valid = 1'b0; sof = 1'b0;
  endtask

  task automatic expect_result(input logic [7:0] data, input bit good);
    if (good) begin
      exp_q.push_back({1'b0, data});
      model_y = data;
    end else begin
      exp_q.push_back({1'b1, model_y});
    end
  endtask

  task automatic send_frame(input logic [7:0] data, input bit good);
    for (int k = 0; k < 7; k++) beat(data[k], k == 0, 1'b1);
`ifdef DEMUX8_PARITY_EN
    beat(data[7], 1'b0, 1'b1);
    expect_result(data, good);
    beat(good ? ^data : ~^data, 1'b0, 1'b1);
`else
    expect_result(data, good);
    beat(data[7], 1'b0, 1'b1);
`endif
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) beat(1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    n_checks++; if (y !== 8'h00) $display("FAIL reset_y got %h want 00", y); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (slot !== 4'd0) $display("FAIL reset_slot got %0d want 0", slot); else n_pass++;
    n_checks++; if ({frame_done, parity_err} !== 2'b00)
      $display("FAIL reset_pulses got %b want 00", {frame_done, parity_err}); else n_pass++;
    for (int k = 0; k < 4; k++) beat(1'b1, 1'b0, 1'b1);
    n_checks++; if ({y, busy, slot} !== {8'h00, 1'b0, 4'd0})
      $display("FAIL idle_no_sof got y=%h busy=%b slot=%0d want 00 0 0", y, busy, slot); else n_pass++;
  endtask

  task automatic test_basic;
    send_frame(8'b0100_1101, 1'b1);
    n_checks++; if (frame_done !== 1'b1) $display("FAIL basic_done got %b want 1", frame_done); else n_pass++;
    n_checks++; if (y !== 8'h4D) $display("FAIL basic_y got %h want 4d", y); else n_pass++;
    n_checks++; if ({busy, slot} !== {1'b0, 4'd0})
      $display("FAIL basic_idle got busy=%b slot=%0d want 0 0", busy, slot); else n_pass++;
    beat(1'b0, 1'b0, 1'b0);
    n_checks++; if (frame_done !== 1'b0) $display("FAIL basic_pulse_width got %b want 0", frame_done); else n_pass++;
  endtask

  task automatic test_stall;
    logic [7:0] data;
    int t0;
    data = 8'b0100_1101;
    t0 = cyc;
    for (int k = 0; k < 4; k++) beat(data[k], k == 0, 1'b1);
    for (int s = 0; s < 3; s++) begin
      beat(1'b1, 1'b0, 1'b0);
      n_checks++; if ({busy, slot} !== {1'b1, 4'd4})
        $display("FAIL stall_hold got busy=%b slot=%0d want 1 4", busy, slot); else n_pass++;
    end
    for (int k = 4; k < 7; k++) beat(data[k], 1'b0, 1'b1);
`ifdef DEMUX8_PARITY_EN
    beat(data[7], 1'b0, 1'b1);
    expect_result(data, 1'b1);
    beat(^data, 1'b0, 1'b1);
`else
    expect_result(data, 1'b1);
    beat(data[7], 1'b0, 1'b1);
`endif
    n_checks++; if ({frame_done, y} !== {1'b1, 8'h4D})
      $display("FAIL stall_result got done=%b y=%h want 1 4d", frame_done, y); else n_pass++;
    n_checks++; if (cyc - t0 !== FLEN + 3)
      $display("FAIL stall_latency got %0d want %0d", cyc - t0, FLEN + 3); else n_pass++;
  endtask

  task automatic test_abort;
    for (int k = 0; k < 5; k++) beat(1'b0, k == 0, 1'b1);
    n_checks++; if ({busy, slot} !== {1'b1, 4'd5})
      $display("FAIL abort_mid_slot got busy=%b slot=%0d want 1 5", busy, slot); else n_pass++;
    send_frame(8'hFF, 1'b1);
    n_checks++; if (y !== 8'hFF) $display("FAIL abort_mid_y got %h want ff", y); else n_pass++;
    for (int k = 0; k < FLEN - 1; k++) beat(1'b0, k == 0, 1'b1);
    n_checks++; if (slot !== 4'(FLEN - 1))
      $display("FAIL abort_last_slot got %0d want %0d", slot, FLEN - 1); else n_pass++;
    send_frame(8'h81, 1'b1);
    n_checks++; if (y !== 8'h81) $display("FAIL abort_last_y got %h want 81", y); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int t1;
    send_frame(8'hA5, 1'b1);
    t1 = cyc;
    n_checks++; if (y !== 8'hA5) $display("FAIL b2b_first got %h want a5", y); else n_pass++;
    send_frame(8'h3C, 1'b1);
    n_checks++; if (cyc - t1 !== FLEN)
      $display("FAIL b2b_spacing got %0d want %0d", cyc - t1, FLEN); else n_pass++;
    n_checks++; if ({frame_done, y} !== {1'b1, 8'h3C})
      $display("FAIL b2b_second got done=%b y=%h want 1 3c", frame_done, y); else n_pass++;
  endtask

  task automatic test_parity;
`ifdef DEMUX8_PARITY_EN
    send_frame(8'h07, 1'b1);
    n_checks++; if ({frame_done, parity_err, y} !== {2'b10, 8'h07})
      $display("FAIL parity_good got done=%b perr=%b y=%h want 1 0 07", frame_done, parity_err, y); else n_pass++;
    send_frame(8'h07, 1'b0);
    n_checks++; if ({frame_done, parity_err, y} !== {2'b01, 8'h07})
      $display("FAIL parity_bad got done=%b perr=%b y=%h want 0 1 07", frame_done, parity_err, y); else n_pass++;
`else
    send_frame(8'h07, 1'b1);
    n_checks++; if ({frame_done, parity_err, y} !== {2'b10, 8'h07})
      $display("FAIL noparity got done=%b perr=%b y=%h want 1 0 07", frame_done, parity_err, y); else n_pass++;
`endif
  endtask

  task automatic test_reset_mid;
    for (int k = 0; k < 3; k++) beat(1'b1, k == 0, 1'b1);
    rst = 1'b1;
    repeat (2) beat(1'b1, 1'b0, 1'b1);
    rst = 1'b0;
    model_y = 8'h00;
    n_checks++; if ({y, busy, slot, frame_done, parity_err} !== {8'h00, 1'b0, 4'd0, 2'b00})
      $display("FAIL reset_mid got y=%h busy=%b slot=%0d want 00 0 0", y, busy, slot); else n_pass++;
    send_frame(8'hC3, 1'b1);
    n_checks++; if (y !== 8'hC3) $display("FAIL after_reset_y got %h want c3", y); else n_pass++;
  endtask

  initial begin
    test_reset;
    test_basic;
    test_stall;
    test_abort;
    test_back_to_back;
    test_parity;
    test_reset_mid;
    repeat (2) beat(1'b0, 1'b0, 1'b0);
    n_checks++; if (exp_q.size() !== 0)
      $display("FAIL scoreboard_drain got %0d pending want 0", exp_q.size()); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/demux8_seq.md
# demux8_seq

Sequential 1-to-8 demultiplexer/deserializer: the receive end of an 8-slot time-division link in which a select-counter-driven 8-to-1 mux serializes eight channels onto one lane. It tracks slot position from a start-of-frame marker, captures each beat into a staging register, and atomically publishes all eight channels when the frame completes. It sits between the serialized lane and ALU operand/flag consumers that need all eight channels stable at once.

## Interface
- WIDTH, 1, bits per slot (per channel); legal 1..16
- clk  in  1  rising-edge clock; the only clock
- rst  in  1  synchronous, active-high reset
- din  in  WIDTH  serialized slot data
- din_valid  in  1  din carries a beat this cycle
- sof  in  1  start of frame; qualified only when din_valid=1; that beat is slot 0
- y  out  8*WIDTH  published channels; slot k at y[k*WIDTH +: WIDTH]
- frame_done  out  1  one-cycle pulse: y just updated
- parity_err  out  1  one-cycle pulse: frame rejected (parity build only; constant 0 otherwise)
- busy  out  1  frame in progress (state FILL)
- slot  out  4  index of the next expected beat; 0 in IDLE

## Operation
- States: IDLE, FILL. Reset -> IDLE.
- IDLE: din_valid&sof -> stage[0]<=din, slot<=1, go FILL. din_valid without sof ignored.
- FILL: each din_valid beat stores din into stage[slot], slot<=slot+1. Cycles with din_valid=0 are stalls: no state change, no timeout.
- Final data beat (slot 7): stage contents plus this beat copied to y; frame_done pulses; return to IDLE; slot<=0.
- Abort: din_valid&sof while in FILL (any slot, including the final one) discards the partial frame, no frame_done, and restarts: stage[0]<=din, slot<=1, stay FILL. sof has priority over completion.
- y changes only on a completed accepted frame; partial frames are never visible. Stage content is not cleared between frames; every slot is rewritten before publish.
- Back-to-back frames: sof on the cycle immediately after a final beat is accepted with no gap.
- Reset mid-frame: partial frame discarded, y cleared.

## Timing
- Reset values: y=0, frame_done=0, parity_err=0, busy=0, slot=0, stage=0.
- All outputs registered. y and frame_done update on the clock edge that samples the final beat (visible the following cycle).
- Minimum frame latency: 8 cycles from sof beat to frame_done (9 with parity build). Throughput: one frame per 8 (9) cycles.
- busy=1 from the cycle after the sof beat until the cycle after the final beat.

## Configuration
- DEMUX8_PARITY_EN defined: frame is 9 beats; slot 8 is a parity beat, only din[0] used. Even parity: XOR of all 8*WIDTH data bits and din[0] must be 0. Pass -> publish y, frame_done. Fail -> y unchanged, parity_err pulses instead of frame_done. slot counts to 8.
- Undefined: 8-beat frames, no parity beat, parity_err tied 0.

## Test plan
- Reset then idle: assert rst 2 cycles mid-frame -> all outputs 0, busy=0; din_valid beats without sof -> y stays 0, no frame_done.
- WIDTH=1, sof on beat of 1, beats 1,0,1,1,0,0,1,0 contiguous -> frame_done 1 cycle after 8th beat, y=8'b0100_1101.
- Same frame with din_valid dropped for 3 cycles after slot 3 -> identical y, frame_done delayed by 3 cycles, busy held.
- Abort: sof at slot 5 with new frame 8'hFF -> no pulse for first frame, y=8'hFF after new frame's 8th beat.
- Back-to-back: frames 8'hA5 then 8'h3C with sof immediately after final beat -> frame_done pulses 8 cycles apart, y=A5 then 3C.
- DEMUX8_PARITY_EN, data 8'h07 with parity beat 1 -> y=07, frame_done; parity beat 0 -> parity_err pulse, y keeps previous value.
